weiflg_fetch: RTL

WEIFLG_FETCH -- requirements
Module: weiflg_fetch

---
 rtl/weiflg_fetch_pkg.sv | 18 +
 rtl/weiflg_fetch_if.sv | 33 +++
 rtl/weiflg_fetch_fifo.sv | 76 +++++++
 rtl/weiflg_fetch.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/weiflg_fetch_pkg.sv
// Shared defaults and FSM encoding for the weight-flag fetch engine.
// Imported by the interface, the prefetch FIFO and the fetch top.
package weiflg_fetch_pkg;

  localparam int PEB_DEF           = 16;
  localparam int WORDS_PER_PEB_DEF = 14;
  localparam int FLG_W_DEF         = 32;
  localparam int ADDR_W_DEF        = 12;
  localparam int FIFO_DEPTH_DEF    = 4;
  localparam int IDX_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/weiflg_fetch_if.sv
// SRAM read port plus the flag-word stream toward the PEB distributor.
// The fetch engine is the master; the SRAM/distributor side is the slave.
interface weiflg_fetch_if
  import weiflg_fetch_pkg::*;
#(
  parameter int FLG_W  = FLG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic [FLG_W-1:0]  sram_rd_data;
  logic              WeiFlg_val_s;
  logic              WeiFlg_rdy_s;
  logic [FLG_W-1:0]  WeiFlg_data_s;
  logic [IDX_W-1:0]  peb_idx;
  logic [IDX_W-1:0]  word_idx;

  modport master (
    output sram_rd_en, sram_rd_addr,
    input  sram_rd_data,
    output WeiFlg_val_s, WeiFlg_data_s, peb_idx, word_idx,
    input  WeiFlg_rdy_s
  );

  modport slave (
    input  sram_rd_en, sram_rd_addr,
    output sram_rd_data,
    input  WeiFlg_val_s, WeiFlg_data_s, peb_idx, word_idx,
    output WeiFlg_rdy_s
  );

endinterface

// File: rtl/weiflg_fetch_fifo.sv
// Synchronous power-of-two FIFO with full/empty/count; accepts push and pop
// in the same cycle. Storage is cleared on reset so the head reads zero.
module weiflg_fifo
  import weiflg_fetch_pkg::*;
#(
  parameter int WIDTH = FLG_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_s;
  logic             rd_s;

  assign full_s  = (count_r == DEPTH_L);
  assign empty_s = (count_r == CNT_W'(0));
  assign rd_s    = pop && !empty_s;
  // A push into a full FIFO is only taken when a pop frees the slot.
  assign wr_s    = push && (!full_s || rd_s);

  // Storage array write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
    end else if (wr_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/weiflg_fetch.sv
// Weight-flag fetch engine: streams PEB*WORDS_PER_PEB flag words from SRAM
// through a small prefetch FIFO to the PEB distributor, tagging each word.
module weiflg_fetch
  import weiflg_fetch_pkg::*;
#(
  parameter int PEB           = PEB_DEF,
  parameter int WORDS_PER_PEB = WORDS_PER_PEB_DEF,
  parameter int FLG_W         = FLG_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  weiflg_fetch_if.master    bus
);

  localparam int TOTAL = PEB * WORDS_PER_PEB;
  localparam int ISS_W = $clog2(TOTAL + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = FC_W + 1;

  localparam logic [ISS_W-1:0] TOTAL_L     = ISS_W'(TOTAL);
  localparam logic [OCC_W-1:0] DEPTH_L     = OCC_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] WORD_LAST_L = IDX_W'(WORDS_PER_PEB - 1);
  localparam logic [IDX_W-1:0] PEB_LAST_L  = IDX_W'(PEB - 1);

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [ISS_W-1:0]  issue_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              inflight_r;
  logic [IDX_W-1:0]  peb_idx_r;
  logic [IDX_W-1:0]  word_idx_r;
  logic              busy_r;
  logic              done_r;

  logic              rd_en_s;
  logic              hs_s;
  logic              last_hs_s;
  logic              push_s;
  logic [OCC_W-1:0]  occ_s;
  logic [FLG_W-1:0]  fifo_rdata_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FC_W-1:0]   fifo_count_s;

  weiflg_fifo #(
    .WIDTH (FLG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (bus.sram_rd_data),
    .pop   (hs_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign hs_s      = !fifo_empty_s && bus.WeiFlg_rdy_s;
  assign last_hs_s = hs_s && (peb_idx_r == PEB_LAST_L) && (word_idx_r == WORD_LAST_L);
  // Reads already in flight count against FIFO space so returning data always fits.
  assign occ_s     = {1'b0, fifo_count_s} + {{FC_W{1'b0}}, inflight_r};
  assign push_s    = inflight_r && (!fifo_full_s || hs_s);

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_hs_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read-issue decision.
  always_comb begin
    rd_en_s = 1'b0;
    if ((state_r == ST_RUN) && (issue_cnt_r < TOTAL_L) && (occ_s < DEPTH_L)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // State register with registered busy/done decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Read issue counter, address and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r <= ISS_W'(0);
      addr_r      <= ADDR_W'(0);
      inflight_r  <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      issue_cnt_r <= ISS_W'(0);
      addr_r      <= base_addr;
      inflight_r  <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
      if (rd_en_s) begin
        issue_cnt_r <= issue_cnt_r + ISS_W'(1);
        addr_r      <= addr_r + ADDR_W'(1);
      end
    end
  end

  // Output word tagging: word index wraps per PEB and carries into the PEB index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peb_idx_r  <= IDX_W'(0);
      word_idx_r <= IDX_W'(0);
    end else if ((state_r == ST_IDLE) && start) begin
      peb_idx_r  <= IDX_W'(0);
      word_idx_r <= IDX_W'(0);
    end else if (hs_s) begin
      if (word_idx_r == WORD_LAST_L) begin
        word_idx_r <= IDX_W'(0);
        peb_idx_r  <= peb_idx_r + IDX_W'(1);
      end else begin
        word_idx_r <= word_idx_r + IDX_W'(1);
      end
    end
  end

  assign busy              = busy_r;
  assign done              = done_r;
  assign bus.sram_rd_en    = rd_en_s;
  assign bus.sram_rd_addr  = addr_r;
  assign bus.WeiFlg_val_s  = !fifo_empty_s;
  assign bus.WeiFlg_data_s = fifo_rdata_s;
  assign bus.peb_idx       = peb_idx_r;
  assign bus.word_idx      = word_idx_r;

endmodule
